// File: rtl/config_readback.sv
// Read-back scanner for the configuration latch banks: captures each bank word from the top bank down,
// exposes it as two 32-bit bus halves and keeps a running XOR checksum of every captured word.
module config_readback #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   debug_wr,
    input  logic                   debug_rd,
    input  logic [5:0]             address,
    input  logic [31:0]            data_in,
    input  logic [DEPTH*WIDTH-1:0] bank_data,
    output logic [31:0]            data_out,
    output logic                   busy
);

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [IDX_BITS-1:0] index_r, index_s;
    logic [WIDTH-1:0]    shadow_r, shadow_s;
    logic [31:0]         csum_r, csum_s;
    logic                start_s;
    logic                advance_s;
    logic [WIDTH-1:0]    bank_word_s;
    logic [63:0]         shadow_ext_s;
    logic                unused_s;

    // Folds a bank word into 32 bits: low half XOR zero-extended upper half.
    function automatic logic [31:0] fold_word(input logic [WIDTH-1:0] word);
        logic [63:0] ext;
        ext = 64'(word);
        return ext[31:0] ^ ext[63:32];
    endfunction

    assign start_s      = debug_wr && (address == 6'h18) && data_in[0];
    assign advance_s    = debug_rd && (address == 6'h14) && (state_r == READY);
    assign bank_word_s  = bank_data[int'(index_r) * WIDTH +: WIDTH];
    assign shadow_ext_s = 64'(shadow_r);
    assign busy         = (state_r != IDLE);
    assign unused_s     = ^data_in[31:1];

    // Next-state logic; a start strobe restarts the scan from any state.
    always_comb begin
        state_s  = state_r;
        index_s  = index_r;
        shadow_s = shadow_r;
        csum_s   = csum_r;
        if (start_s) begin
            state_s = CAPTURE;
            index_s = IDX_BITS'(DEPTH - 1);
            csum_s  = 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                CAPTURE: begin
                    shadow_s = bank_word_s;
                    csum_s   = csum_r ^ fold_word(bank_word_s);
                    state_s  = READY;
                end
                READY: begin
                    if (advance_s) begin
                        if (index_r == '0) begin
                            state_s = IDLE;
                        end else begin
                            index_s = index_r - IDX_BITS'(1);
                            state_s = CAPTURE;
                        end
                    end else begin
                        state_s = READY;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State registers; reset clears any partial scan immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            index_r  <= '0;
            shadow_r <= '0;
            csum_r   <= 32'h0;
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            shadow_r <= shadow_s;
            csum_r   <= csum_s;
        end
    end

    // Bus read mux; data_out follows address combinationally.
    always_comb begin
        data_out = 32'h0;
        case (address)
            6'h10:   data_out = shadow_ext_s[31:0];
            6'h14:   data_out = shadow_ext_s[63:32];
            6'h18:   data_out = {24'h0, 6'(index_r), (state_r == READY), (state_r != IDLE)};
            6'h1C:   data_out = csum_r;
            default: data_out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_config_readback.sv
// Scoreboarded bench for config_readback: a 8x64 instance for scan/restart/reset checks and a
// 4x40 instance for the narrow upper-half case.
module tb_config_readback;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_a, rd_a, wr_b, rd_b;
    logic [5:0]       address;
    logic [31:0]      data_in;
    logic [8*64-1:0]  bank_a;
    logic [4*40-1:0]  bank_b;
    logic [31:0]      dout_a, dout_b;
    logic             busy_a, busy_b;

    logic [31:0]      exp_q[$];
    bit               sel_q[$];
    string            name_q[$];
    int               total = 0;
    int               bad = 0;

    logic [31:0]      mon_exp, mon_act;
    bit               mon_sel;
    string            mon_name;
    logic [31:0]      csum_m;

    always #5 clk = ~clk;

    config_readback #(.DEPTH(8), .WIDTH(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_a), .debug_rd(rd_a), .address(address),
        .data_in(data_in), .bank_data(bank_a), .data_out(dout_a), .busy(busy_a)
    );

    config_readback #(.DEPTH(4), .WIDTH(40)) dut_b (
        .clk(clk), .rst_n(rst_n), .debug_wr(wr_b), .debug_rd(rd_b), .address(address),
        .data_in(data_in), .bank_data(bank_b), .data_out(dout_b), .busy(busy_b)
    );

    function automatic logic [31:0] lo_w(input int i);
        return 32'(32'hA000_0000 + i);
    endfunction

    function automatic logic [31:0] hi_w(input int i);
        return 32'(32'h1000_0000 + i);
    endfunction

    function automatic logic [31:0] status(input int idx, input bit rdy, input bit bsy);
        return {24'h0, 6'(idx), rdy, bsy};
    endfunction

    // Monitor: every read strobe pops one expectation and compares the selected DUT.
    always @(negedge clk) begin
        if (rd_a || rd_b) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read actual=%08h required=<no expectation>", rd_b ? dout_b : dout_a);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_sel  = sel_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = mon_sel ? dout_b : dout_a;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL %s actual=%08h required=%08h", mon_name, mon_act, mon_exp);
                end
                if (address == 6'h18) begin
                    total++;
                    if ((mon_sel ? busy_b : busy_a) !== mon_exp[0]) begin
                        bad++;
                        $display("FAIL %s_busy actual=%0b required=%0b", mon_name,
                                 mon_sel ? busy_b : busy_a, mon_exp[0]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [5:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        if (sel) wr_b = 1'b1;
        else     wr_a = 1'b1;
        cyc();
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [5:0] a, input logic [31:0] e, input string n);
        address = a;
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(n);
        if (sel) rd_b = 1'b1;
        else     rd_a = 1'b1;
        cyc();
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_a    = 1'b0;
        rd_a    = 1'b0;
        wr_b    = 1'b0;
        rd_b    = 1'b0;
        address = 6'h0;
        data_in = 32'h0;
        for (int i = 0; i < 8; i++) bank_a[i*64 +: 64] = {hi_w(i), lo_w(i)};
        bank_b = '0;
        bank_b[3*40 +: 40] = 40'h5C_DEAD_BEEF;
        bank_b[2*40 +: 40] = 40'hAB_1234_5678;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Reset state
        rd(0, 6'h18, 32'h0, "reset_status");
        rd(0, 6'h10, 32'h0, "reset_lo");
        rd(0, 6'h14, 32'h0, "reset_hi");
        rd(0, 6'h1C, 32'h0, "reset_csum");
        rd(0, 6'h3C, 32'h0, "unmapped_addr");
        rd(1, 6'h18, 32'h0, "reset_status_b");

        // Ignored writes
        wr(0, 6'h18, 32'hFFFF_FFFE);
        rd(0, 6'h18, 32'h0, "start_bit0_clear");
        wr(0, 6'h10, 32'h0000_0001);
        rd(0, 6'h18, 32'h0, "write_other_addr");

        // Start and hold in READY under side-effect-free reads
        wr(0, 6'h18, 32'h1);
        rd(0, 6'h18, status(7, 1'b0, 1'b1), "capture_status");
        rd(0, 6'h18, status(7, 1'b1, 1'b1), "ready_status");
        repeat (5) begin
            rd(0, 6'h10, lo_w(7), "hold_lo");
            rd(0, 6'h1C, lo_w(7) ^ hi_w(7), "hold_csum");
        end
        rd(0, 6'h18, status(7, 1'b1, 1'b1), "hold_status");

        // Full scan 7..0
        csum_m = 32'h0;
        for (int i = 7; i >= 0; i--) begin
            csum_m = csum_m ^ lo_w(i) ^ hi_w(i);
            rd(0, 6'h10, lo_w(i), "scan_lo");
            rd(0, 6'h1C, csum_m, "scan_csum");
            rd(0, 6'h14, hi_w(i), "scan_hi");
            if (i > 0) rd(0, 6'h18, status(i - 1, 1'b0, 1'b1), "scan_capture_status");
            else       rd(0, 6'h18, 32'h0, "scan_end_status");
        end
        rd(0, 6'h1C, csum_m, "final_csum");
        rd(0, 6'h10, lo_w(0), "retained_lo");

        // Restart mid-scan at index 3
        wr(0, 6'h18, 32'h1);
        rd(0, 6'h18, status(7, 1'b0, 1'b1), "pre_capture_status");
        csum_m = 32'h0;
        for (int i = 7; i >= 4; i--) begin
            csum_m = csum_m ^ lo_w(i) ^ hi_w(i);
            rd(0, 6'h14, hi_w(i), "pre_hi");
            rd(0, 6'h18, status(i - 1, 1'b0, 1'b1), "pre_next_status");
        end
        csum_m = csum_m ^ lo_w(3) ^ hi_w(3);
        rd(0, 6'h18, status(3, 1'b1, 1'b1), "pre_restart_status");
        rd(0, 6'h1C, csum_m, "pre_restart_csum");
        wr(0, 6'h18, 32'h1);
        rd(0, 6'h18, status(7, 1'b0, 1'b1), "restart_status");
        rd(0, 6'h1C, lo_w(7) ^ hi_w(7), "restart_csum");
        rd(0, 6'h14, hi_w(7), "restart_word");
        for (int i = 6; i >= 5; i--) begin
            rd(0, 6'h18, status(i, 1'b0, 1'b1), "restart_capture_status");
            rd(0, 6'h14, hi_w(i), "restart_hi");
        end
        rd(0, 6'h18, status(4, 1'b0, 1'b1), "idx4_capture_status");
        rd(0, 6'h18, status(4, 1'b1, 1'b1), "idx4_ready_status");

        // Asynchronous reset in READY at index 4
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        rd(0, 6'h18, 32'h0, "post_reset_status");
        rd(0, 6'h10, 32'h0, "post_reset_lo");
        rd(0, 6'h1C, 32'h0, "post_reset_csum");
        rd(0, 6'h14, 32'h0, "post_reset_hi");
        wr(0, 6'h18, 32'h1);
        rd(0, 6'h18, status(7, 1'b0, 1'b1), "fresh_capture_status");
        rd(0, 6'h10, lo_w(7), "fresh_lo");
        rd(0, 6'h1C, lo_w(7) ^ hi_w(7), "fresh_csum");

        // Narrow instance: upper half zero-extended
        wr(1, 6'h18, 32'h1);
        rd(1, 6'h18, status(3, 1'b0, 1'b1), "w40_capture_status");
        rd(1, 6'h10, 32'hDEAD_BEEF, "w40_b3_lo");
        rd(1, 6'h14, 32'h0000_005C, "w40_b3_hi");
        rd(1, 6'h18, status(2, 1'b0, 1'b1), "w40_next_status");
        rd(1, 6'h10, 32'h1234_5678, "w40_b2_lo");
        rd(1, 6'h1C, 32'hDEAD_BEEF ^ 32'h0000_005C ^ 32'h1234_5678 ^ 32'h0000_00AB, "w40_csum");
        rd(1, 6'h14, 32'h0000_00AB, "w40_upper");

        cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
